// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART word transmit controller
package UART_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SEND = 3'd2,
    S_WAIT = 3'd3,
    S_GAP  = 3'd4,
    S_DONE = 3'd5
  } word_tx_state_t;

  // Byte index width; a one-byte word still gets a 1-bit index.
  function automatic int idx_width(input int nbytes);
    return (nbytes <= 1) ? 1 : $clog2(nbytes);
  endfunction

endpackage

// File: rtl/uart_gap_counter.sv
// rtl/uart_gap_counter.sv - counts the idle cycles inserted between bytes of one word
module uart_gap_counter #(
  parameter int GAP_CYCLES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int LAST  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Expire on the last gap cycle so the FSM leaves after exactly GAP_CYCLES cycles.
  assign expire = en && (cnt == CNT_W'(LAST));

endmodule

// File: rtl/uart_word_tx_ctrl.sv
// rtl/uart_word_tx_ctrl.sv - splits a word into characters and sequences them to a byte transmitter
module uart_word_tx_ctrl
  import UART_pkg::*;
#(
  parameter int  DATA_W     = 32,
  parameter int  BYTE_W     = 8,
  parameter int  MSB_FIRST  = 0,
  parameter int  GAP_CYCLES = 0,
  localparam int NBYTES     = DATA_W / BYTE_W,
  localparam int IDX_W      = idx_width(NBYTES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] word_in,
  input  logic              abort,
  input  logic              byte_ready,
  input  logic              byte_done,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_send,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  byte_idx,
  output word_tx_state_t    state_out
);

  if (BYTE_W < 1 || DATA_W < BYTE_W || (DATA_W % BYTE_W) != 0) begin : g_bad_params
    $error("uart_word_tx_ctrl: DATA_W must be a positive multiple of BYTE_W");
  end

  word_tx_state_t     state, state_nxt;
  logic [DATA_W-1:0]  shadow;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   sel;
  logic               last_byte;
  logic               gap_expire;

  assign last_byte = (idx_q == IDX_W'(NBYTES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Index only moves when WAIT finishes a byte, keeping tx_data stable through SEND/WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      idx_q  <= '0;
    end else if (state == S_IDLE) begin
      if (start) begin
        shadow <= word_in;
        idx_q  <= '0;
      end
    end else if (state == S_WAIT && byte_done && !abort && !last_byte) begin
      idx_q <= idx_q + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort && state != S_IDLE) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start) state_nxt = S_LOAD;
        S_LOAD: if (byte_ready) state_nxt = S_SEND;
        S_SEND: state_nxt = S_WAIT;
        S_WAIT: begin
          if (byte_done) begin
            if (last_byte)           state_nxt = S_DONE;
            else if (GAP_CYCLES > 0) state_nxt = S_GAP;
            else                     state_nxt = S_LOAD;
          end
        end
        S_GAP:  if (gap_expire) state_nxt = S_LOAD;
        S_DONE: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    tx_send   = (state == S_SEND);
    done      = (state == S_DONE);
    busy      = (state != S_IDLE);
    byte_idx  = idx_q;
    state_out = state;
  end

  always_comb begin
    sel = (MSB_FIRST != 0) ? (IDX_W'(NBYTES - 1) - idx_q) : idx_q;
  end

  always_comb begin
    tx_data = '0;
    for (int b = 0; b < NBYTES; b++) begin
      if (sel == IDX_W'(b)) tx_data = shadow[b*BYTE_W +: BYTE_W];
    end
  end

  uart_gap_counter #(
    .GAP_CYCLES(GAP_CYCLES)
  ) u_gap (
    .clk   (clk),
    .rst   (rst),
    .clear (state != S_GAP),
    .en    (state == S_GAP),
    .expire(gap_expire)
  );

endmodule

// File: tb/tb_uart_word_tx_ctrl.sv
// tb/tb_uart_word_tx_ctrl.sv - directed self-checking bench for uart_word_tx_ctrl
`timescale 1ns/1ps
module tb_uart_word_tx_ctrl;
  import UART_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  start_v  = '0;
  logic [3:0]  abort_v  = '0;
  logic [3:0]  bd_force = '0;
  logic [3:0]  byte_done_v, tx_send_v, busy_v, done_v;
  logic        byte_ready = 1'b1;
  logic [31:0] word32 = '0;
  logic [7:0]  word8  = '0;
  logic [7:0]  txd [4];
  logic [1:0]  idx0, idx1, idx2;
  logic [0:0]  idx3;
  word_tx_state_t st [4];

  int total = 0;
  int bad   = 0;

  logic [7:0] sent0[$], sent1[$], sent2[$], sent3[$];
  logic [1:0] sidx0[$];
  int         gap_runs[$];
  int         done_cnt [4] = '{0, 0, 0, 0};
  int         run = 0;

  always #5 clk = ~clk;

  uart_word_tx_ctrl #(.DATA_W(32), .BYTE_W(8), .MSB_FIRST(0), .GAP_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .word_in(word32), .abort(abort_v[0]),
    .byte_ready(byte_ready), .byte_done(byte_done_v[0]), .tx_data(txd[0]), .tx_send(tx_send_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .byte_idx(idx0), .state_out(st[0]));

  uart_word_tx_ctrl #(.DATA_W(32), .BYTE_W(8), .MSB_FIRST(1), .GAP_CYCLES(0)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .word_in(word32), .abort(abort_v[1]),
    .byte_ready(byte_ready), .byte_done(byte_done_v[1]), .tx_data(txd[1]), .tx_send(tx_send_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .byte_idx(idx1), .state_out(st[1]));

  uart_word_tx_ctrl #(.DATA_W(32), .BYTE_W(8), .MSB_FIRST(0), .GAP_CYCLES(3)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .word_in(word32), .abort(abort_v[2]),
    .byte_ready(byte_ready), .byte_done(byte_done_v[2]), .tx_data(txd[2]), .tx_send(tx_send_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .byte_idx(idx2), .state_out(st[2]));

  uart_word_tx_ctrl #(.DATA_W(8), .BYTE_W(8), .MSB_FIRST(0), .GAP_CYCLES(0)) u3 (
    .clk(clk), .rst(rst), .start(start_v[3]), .word_in(word8), .abort(abort_v[3]),
    .byte_ready(byte_ready), .byte_done(byte_done_v[3]), .tx_data(txd[3]), .tx_send(tx_send_v[3]),
    .busy(busy_v[3]), .done(done_v[3]), .byte_idx(idx3), .state_out(st[3]));

  // Byte transmitter model: byte_done pulses 10 cycles after each tx_send.
  for (genvar k = 0; k < 4; k++) begin : g_bfm
    int cnt;
    always @(posedge clk or posedge rst) begin
      if (rst)                cnt <= 0;
      else if (tx_send_v[k])  cnt <= 10;
      else if (cnt > 0)       cnt <= cnt - 1;
    end
    assign byte_done_v[k] = (cnt == 1) | bd_force[k];
  end

  always @(negedge clk) begin
    if (tx_send_v[0]) begin sent0.push_back(txd[0]); sidx0.push_back(idx0); end
    if (tx_send_v[1]) sent1.push_back(txd[1]);
    if (tx_send_v[2]) sent2.push_back(txd[2]);
    if (tx_send_v[3]) sent3.push_back(txd[3]);
    for (int k = 0; k < 4; k++) if (done_v[k]) done_cnt[k] <= done_cnt[k] + 1;
    if (st[2] == S_GAP) begin
      run <= run + 1;
    end else if (run > 0) begin
      gap_runs.push_back((st[2] == S_LOAD) ? run : -run);
      run <= 0;
    end
  end

  task automatic pulse_start(input int k);
    @(negedge clk); start_v[k] = 1'b1;
    @(negedge clk); start_v[k] = 1'b0;
  endtask

  task automatic test_reset;
    word32 = 32'hFFFF_FFFF;
    word8  = 8'hFF;
    #12;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (busy_v[k] !== 1'b0 || tx_send_v[k] !== 1'b0 || done_v[k] !== 1'b0 || txd[k] !== 8'h00 || st[k] !== S_IDLE) begin
        bad++;
        $display("FAIL reset_outputs inst=%0d busy=%b send=%b done=%b data=%h state=%0d required 0 0 0 00 IDLE",
                 k, busy_v[k], tx_send_v[k], done_v[k], txd[k], st[k]);
      end
    end
    total++;
    if (idx0 !== 2'd0 || idx1 !== 2'd0 || idx2 !== 2'd0 || idx3 !== 1'b0) begin
      bad++;
      $display("FAIL reset_byte_idx got %0d %0d %0d %0d required 0", idx0, idx1, idx2, idx3);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_lsb_first;
    logic [7:0] exp [4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    int base = sent0.size();
    int d0 = done_cnt[0];
    int n = 0;
    word32 = 32'hA1B2_C3D4;
    pulse_start(0);
    while (done_cnt[0] < d0 + 1 && n < 300) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    total++;
    if (sent0.size() - base !== 4) begin
      bad++; $display("FAIL lsb_send_count got %0d required 4", sent0.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (sent0[base+i] !== exp[i]) begin
          bad++; $display("FAIL lsb_byte%0d got %h required %h", i, sent0[base+i], exp[i]);
        end
      end
    end
    total++;
    if (done_cnt[0] - d0 !== 1 || busy_v[0] !== 1'b0) begin
      bad++; $display("FAIL lsb_done got done=%0d busy=%b required 1 0", done_cnt[0] - d0, busy_v[0]);
    end
  endtask

  task automatic test_msb_first;
    logic [7:0] exp [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    int base = sent1.size();
    int d1 = done_cnt[1];
    int n = 0;
    word32 = 32'hA1B2_C3D4;
    pulse_start(1);
    while (done_cnt[1] < d1 + 1 && n < 300) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    total++;
    if (sent1.size() - base !== 4) begin
      bad++; $display("FAIL msb_send_count got %0d required 4", sent1.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (sent1[base+i] !== exp[i]) begin
          bad++; $display("FAIL msb_byte%0d got %h required %h", i, sent1[base+i], exp[i]);
        end
      end
    end
    total++;
    if (done_cnt[1] - d1 !== 1) begin
      bad++; $display("FAIL msb_done got %0d required 1", done_cnt[1] - d1);
    end
  endtask

  task automatic test_gap;
    logic [7:0] exp [4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    int base = sent2.size();
    int gbase = gap_runs.size();
    int d2 = done_cnt[2];
    int n = 0;
    word32 = 32'hA1B2_C3D4;
    pulse_start(2);
    while (done_cnt[2] < d2 + 1 && n < 400) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    total++;
    if (sent2.size() - base !== 4) begin
      bad++; $display("FAIL gap_send_count got %0d required 4", sent2.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (sent2[base+i] !== exp[i]) begin
          bad++; $display("FAIL gap_byte%0d got %h required %h", i, sent2[base+i], exp[i]);
        end
      end
    end
    total++;
    if (gap_runs.size() - gbase !== 3) begin
      bad++; $display("FAIL gap_run_count got %0d required 3", gap_runs.size() - gbase);
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (gap_runs[gbase+i] !== 3) begin
          bad++; $display("FAIL gap_run%0d got %0d required 3 then LOAD", i, gap_runs[gbase+i]);
        end
      end
    end
  endtask

  task automatic test_ignore_restart;
    logic [7:0] exp [4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    int base = sent0.size();
    int d0 = done_cnt[0];
    int n = 0;
    word32 = 32'hA1B2_C3D4;
    pulse_start(0);
    repeat (20) @(negedge clk);
    word32 = 32'h1122_3344;
    start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0; word32 = 32'hDEAD_BEEF;
    repeat (15) @(negedge clk); word32 = 32'h0F0F_0F0F;
    while (done_cnt[0] < d0 + 1 && n < 300) begin @(negedge clk); n++; end
    repeat (30) @(negedge clk);
    total++;
    if (sent0.size() - base !== 4) begin
      bad++; $display("FAIL restart_send_count got %0d required 4", sent0.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (sent0[base+i] !== exp[i]) begin
          bad++; $display("FAIL restart_byte%0d got %h required %h", i, sent0[base+i], exp[i]);
        end
      end
    end
    total++;
    if (done_cnt[0] - d0 !== 1 || busy_v[0] !== 1'b0) begin
      bad++; $display("FAIL restart_done got done=%0d busy=%b required 1 0", done_cnt[0] - d0, busy_v[0]);
    end
  endtask

  task automatic test_abort;
    logic [7:0] exp [4] = '{8'h88, 8'h77, 8'h66, 8'h55};
    int d0 = done_cnt[0];
    int n = 0;
    int base;
    word32 = 32'hA1B2_C3D4;
    pulse_start(0);
    while (!(idx0 == 2'd2 && st[0] == S_WAIT) && n < 300) begin @(negedge clk); n++; end
    total++;
    if (!(idx0 == 2'd2 && st[0] == S_WAIT)) begin
      bad++; $display("FAIL abort_reach_wait2 got idx=%0d state=%0d required 2 WAIT", idx0, st[0]);
    end
    abort_v[0] = 1'b1;
    bd_force[0] = 1'b1;
    @(posedge clk); #1;
    total++;
    if (st[0] !== S_IDLE || busy_v[0] !== 1'b0) begin
      bad++; $display("FAIL abort_to_idle got state=%0d busy=%b required IDLE 0", st[0], busy_v[0]);
    end
    @(negedge clk); abort_v[0] = 1'b0; bd_force[0] = 1'b0;
    repeat (15) @(negedge clk);
    total++;
    if (done_cnt[0] !== d0 || busy_v[0] !== 1'b0) begin
      bad++; $display("FAIL abort_no_done got done=%0d busy=%b required %0d 0", done_cnt[0], busy_v[0], d0);
    end
    base = sent0.size();
    word32 = 32'h5566_7788;
    pulse_start(0);
    n = 0;
    while (done_cnt[0] < d0 + 1 && n < 300) begin @(negedge clk); n++; end
    total++;
    if (sent0.size() - base !== 4) begin
      bad++; $display("FAIL abort_resend_count got %0d required 4", sent0.size() - base);
    end else begin
      total++;
      if (sidx0[base] !== 2'd0) begin
        bad++; $display("FAIL abort_resend_idx got %0d required 0", sidx0[base]);
      end
      for (int i = 0; i < 4; i++) begin
        total++;
        if (sent0[base+i] !== exp[i]) begin
          bad++; $display("FAIL abort_resend_byte%0d got %h required %h", i, sent0[base+i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_word;
    int d3;
    int base;
    int n = 0;
    word8 = 8'h5A;
    pulse_start(3);
    while (st[3] != S_WAIT && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    total++;
    if (st[3] !== S_IDLE || busy_v[3] !== 1'b0 || txd[3] !== 8'h00 || idx3 !== 1'b0 || tx_send_v[3] !== 1'b0 || done_v[3] !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got state=%0d busy=%b data=%h idx=%0d send=%b done=%b required IDLE 0 00 0 0 0",
               st[3], busy_v[3], txd[3], idx3, tx_send_v[3], done_v[3]);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (st[3] !== S_IDLE) begin
      bad++; $display("FAIL reset_release_state got %0d required IDLE", st[3]);
    end
    d3 = done_cnt[3];
    base = sent3.size();
    pulse_start(3);
    n = 0;
    while (done_cnt[3] < d3 + 1 && n < 100) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    total++;
    if (sent3.size() - base !== 1 || done_cnt[3] - d3 !== 1) begin
      bad++; $display("FAIL single_byte_counts got sends=%0d dones=%0d required 1 1", sent3.size() - base, done_cnt[3] - d3);
    end else begin
      total++;
      if (sent3[base] !== 8'h5A) begin
        bad++; $display("FAIL single_byte_data got %h required 5a", sent3[base]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_gap();
    test_ignore_restart();
    test_abort();
    test_reset_mid_word();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
